// File: rtl/out_serializer.sv
// Four-port change-driven output serializer. Each 16-bit processor port is
// watched for changes; a changed value is captured and sent to an external
// receiver as two bytes (low then high) over a four-phase valid/ack handshake.
// Ports are served round-robin and lost intermediate updates are flagged.
module out_serializer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] p0,
  input  logic [15:0] p1,
  input  logic [15:0] p2,
  input  logic [15:0] p3,
  input  logic        ack,
  output logic [7:0]  data_out,
  output logic        valid,
  output logic [1:0]  port_id,
  output logic        hi,
  output logic        busy,
  output logic [3:0]  overflow
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_REQ  = 3'd1,
    LO_WAIT = 3'd2,
    HI_REQ  = 3'd3,
    HI_WAIT = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  logic [15:0] port_in  [4];
  logic [15:0] shadow_q [4];
  logic [15:0] snap_q   [4];
  logic [15:0] snap_sel;

  logic [3:0]  change;
  logic [3:0]  grant_vec;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  overflow_q, overflow_d;

  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic        gnt_found;
  logic        grant;

  logic [15:0] tx_q, tx_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [1:0]  port_id_q, port_id_d;
  logic        hi_q, hi_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  assign port_in[0] = p0;
  assign port_in[1] = p1;
  assign port_in[2] = p2;
  assign port_in[3] = p3;

  // ack crosses from the receiver's domain through a plain flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Per-port change detection and pending/overflow bookkeeping. A port that
  // is granted on the same edge it changes keeps its pending bit, so the new
  // value goes out in a later frame without counting as a lost update.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      assign change[gi]     = (port_in[gi] != shadow_q[gi]);
      assign grant_vec[gi]  = grant && (gnt_idx == 2'(gi));
      assign pend_d[gi]     = grant_vec[gi] ? change[gi] : (pend_q[gi] | change[gi]);
      assign overflow_d[gi] = overflow_q[gi] | (change[gi] & pend_q[gi] & ~grant_vec[gi]);
    end
  endgenerate

  // Round-robin pick: search starts one past the last port served
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!gnt_found && pend_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant    = (state_q == IDLE) && gnt_found;
  assign snap_sel = snap_q[gnt_idx];

  // Shadow follows each port every cycle; snapshot captures each new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= port_in[i];
        if (change[i]) begin
          snap_q[i] <= port_in[i];
        end
      end
    end
  end

  // Handshake FSM next-state and registered-output next values
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    data_out_d   = data_out_q;
    port_id_d    = port_id_q;
    hi_d         = hi_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          tx_d       = snap_sel;
          data_out_d = snap_sel[7:0];
          port_id_d  = gnt_idx;
          hi_d       = 1'b0;
          state_d    = LO_REQ;
        end
      end
      LO_REQ: begin
        if (ack_s) begin
          state_d = LO_WAIT;
        end
      end
      LO_WAIT: begin
        if (!ack_s) begin
          data_out_d = tx_q[15:8];
          hi_d       = 1'b1;
          state_d    = HI_REQ;
        end
      end
      HI_REQ: begin
        if (ack_s) begin
          state_d = HI_WAIT;
        end
      end
      HI_WAIT: begin
        if (!ack_s) begin
          last_grant_d = port_id_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == LO_REQ) || (state_d == HI_REQ);
    busy_d  = (state_d != IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      data_out_q   <= '0;
      port_id_q    <= '0;
      hi_q         <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 2'd3;
      pend_q       <= '0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      data_out_q   <= data_out_d;
      port_id_q    <= port_id_d;
      hi_q         <= hi_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      overflow_q   <= overflow_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign port_id  = port_id_q;
  assign hi       = hi_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_out_serializer.sv
// Bench for out_serializer: directed scenarios followed by randomized bursts
// of port changes, checked against a frame-level round-robin model.
module tb_out_serializer;

  localparam int S = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] p0, p1, p2, p3;
  logic        ack;
  logic [7:0]  data_out;
  logic        valid;
  logic [1:0]  port_id;
  logic        hi;
  logic        busy;
  logic [3:0]  overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] cur [4];
  int          exp_last;
  logic [3:0]  exp_ovf;
  int          exp_port_q [$];
  logic [15:0] exp_val_q  [$];

  out_serializer #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0       (p0),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .ack      (ack),
    .data_out (data_out),
    .valid    (valid),
    .port_id  (port_id),
    .hi       (hi),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_port(input int idx, input logic [15:0] v);
    case (idx)
      0: p0 = v;
      1: p1 = v;
      2: p2 = v;
      default: p3 = v;
    endcase
    cur[idx] = v;
  endtask

  task automatic wait_valid(input logic lvl, input string tag);
    int n = 0;
    while (valid !== lvl && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_wait_valid"}, 32'(valid === lvl), 32'd1);
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_wait_idle"}, 32'(busy === 1'b0), 32'd1);
  endtask

  // Receiver: full four-phase handshake for both bytes of one frame
  task automatic recv_frame(input int ep, input logic [15:0] ev, input bit chk_len, input string tag);
    int t0;
    logic [7:0] lo_b;
    logic [7:0] hi_b;
    wait_valid(1'b1, {tag, "_lo"});
    t0 = cyc;
    lo_b = data_out;
    chk({tag, "_lo_port"}, 32'(port_id), 32'(ep));
    chk({tag, "_lo_hi"},   32'(hi), 32'd0);
    chk({tag, "_lo_data"}, 32'(data_out), 32'(ev[7:0]));
    ack = 1'b1;
    wait_valid(1'b0, {tag, "_lo_drop"});
    ack = 1'b0;
    wait_valid(1'b1, {tag, "_hi"});
    hi_b = data_out;
    chk({tag, "_hi_port"}, 32'(port_id), 32'(ep));
    chk({tag, "_hi_hi"},   32'(hi), 32'd1);
    chk({tag, "_hi_data"}, 32'(data_out), 32'(ev[15:8]));
    ack = 1'b1;
    wait_valid(1'b0, {tag, "_hi_drop"});
    ack = 1'b0;
    wait_busy_low(tag);
    if (chk_len) chk({tag, "_len"}, 32'(cyc - t0), 32'(4 * (S + 1)));
    $display("frame %s port=%0d bytes=%02h,%02h expected=%04h", tag, ep, lo_b, hi_b, ev);
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] set);
    int r = -1;
    for (int k = 1; k <= 4; k++) begin
      int p = (last + k) % 4;
      if (r < 0 && set[p]) r = p;
    end
    return r;
  endfunction

  initial begin
    logic [3:0]  mask;
    logic [3:0]  pset;
    int          lens [4];
    logic [15:0] vals [4][3];
    logic [15:0] prev;
    logic [15:0] v;
    int          g, last, pp, n;
    bit          first, quiet, stable;

    rst_n = 1'b0;
    ack   = 1'b0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    for (int i = 0; i < 4; i++) cur[i] = '0;
    exp_last = 3;
    exp_ovf  = 4'b0000;

    // Reset state
    repeat (3) tick();
    chk("rst_valid",    32'(valid), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_data",     32'(data_out), 32'd0);
    chk("rst_port_id",  32'(port_id), 32'd0);
    chk("rst_hi",       32'(hi), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("zero_ports_idle", 32'(busy), 32'd0);

    // Three ports change together: served 0, 2, 3 after reset
    set_port(0, 16'h1111);
    set_port(2, 16'h2222);
    set_port(3, 16'h3333);
    recv_frame(0, 16'h1111, 1'b1, "rr_p0");
    recv_frame(2, 16'h2222, 1'b1, "rr_p2");
    recv_frame(3, 16'h3333, 1'b1, "rr_p3");
    exp_last = 3;

    // Single port frame
    set_port(1, 16'hBEEF);
    recv_frame(1, 16'hBEEF, 1'b1, "beef");
    chk("beef_ovf", 32'(overflow), 32'(exp_ovf));
    exp_last = 1;

    // Change on the grant edge: old value sent, new value follows, no overflow
    set_port(1, 16'h00AA);
    tick();
    set_port(1, 16'h00BB);
    tick();
    recv_frame(1, 16'h00AA, 1'b0, "grant_edge_a");
    recv_frame(1, 16'h00BB, 1'b1, "grant_edge_b");
    chk("grant_edge_ovf", 32'(overflow), 32'(exp_ovf));

    // Port 2 updated repeatedly while port 0 is in flight
    set_port(0, 16'h4444);
    tick();
    tick();
    set_port(2, 16'h0001);
    tick();
    set_port(2, 16'h0002);
    tick();
    set_port(2, 16'h0003);
    tick();
    recv_frame(0, 16'h4444, 1'b0, "inflight_p0");
    recv_frame(2, 16'h0003, 1'b1, "lost_p2");
    exp_ovf[2] = 1'b1;
    chk("lost_ovf", 32'(overflow), 32'(exp_ovf));

    // Stall in LO_REQ for 100 cycles, then measure ack-to-valid-fall latency
    set_port(3, 16'h9A5C);
    wait_valid(1'b1, "stall");
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid !== 1'b1 || data_out !== 8'h5C || hi !== 1'b0 || port_id !== 2'd3) stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    ack = 1'b1;
    n = 0;
    while (valid !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk("ack_latency", 32'(n), 32'(S + 1));
    ack = 1'b0;
    wait_valid(1'b1, "stall_hi");
    chk("stall_hi_data", 32'(data_out), 32'h9A);
    chk("stall_hi_hi",   32'(hi), 32'd1);
    ack = 1'b1;
    wait_valid(1'b0, "stall_hi_drop");
    ack = 1'b0;
    wait_busy_low("stall");
    $display("frame stall port=3 value=9a5c latency=%0d", n);
    exp_last = 3;

    // Reset asserted during HI_REQ aborts the frame
    set_port(0, 16'h7E01);
    wait_valid(1'b1, "abort_lo");
    ack = 1'b1;
    wait_valid(1'b0, "abort_lo_drop");
    ack = 1'b0;
    wait_valid(1'b1, "abort_hi");
    chk("abort_in_hi", 32'(hi), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_port(i, 16'h0000);
    #1;
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_ovf",   32'(overflow), 32'd0);
    chk("abort_data",  32'(data_out), 32'd0);
    tick();
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("abort_quiet", 32'(quiet), 32'd1);
    $display("abort reset during HI_REQ quiet=%0d", quiet);
    exp_ovf  = 4'b0000;
    exp_last = 3;

    // Non-zero port across reset release produces a frame right away
    rst_n = 1'b0;
    set_port(2, 16'hCAFE);
    tick();
    rst_n = 1'b1;
    tick();
    chk("release_r1_valid", 32'(valid), 32'd0);
    tick();
    chk("release_r2_valid", 32'(valid), 32'd1);
    chk("release_r2_port",  32'(port_id), 32'd2);
    recv_frame(2, 16'hCAFE, 1'b1, "release");
    exp_last = 2;

    // Randomized bursts: up to three consecutive changes per port from idle
    for (int it = 0; it < 20; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int p = 0; p < 4; p++) begin
        lens[p] = mask[p] ? int'($urandom_range(1, 3)) : 0;
        prev = cur[p];
        for (int s = 0; s < 3; s++) begin
          v = 16'($urandom);
          if (v == prev) v = v ^ 16'h0001;
          vals[p][s] = v;
          if (s < lens[p]) prev = v;
        end
      end
      for (int s = 0; s < 3; s++) begin
        for (int p = 0; p < 4; p++) begin
          if (s < lens[p]) set_port(p, vals[p][s]);
        end
        tick();
      end

      // Model: first winner sends its first value; its later changes re-queue it
      g = rr_pick(exp_last, mask);
      exp_port_q.push_back(g);
      exp_val_q.push_back(vals[g][0]);
      pset = mask;
      pset[g] = (lens[g] >= 2);
      for (int p = 0; p < 4; p++) begin
        if (p != g && lens[p] >= 2) exp_ovf[p] = 1'b1;
      end
      if (lens[g] == 3) exp_ovf[g] = 1'b1;
      last = g;
      while (pset != 4'b0000) begin
        pp = rr_pick(last, pset);
        exp_port_q.push_back(pp);
        exp_val_q.push_back(vals[pp][lens[pp] - 1]);
        pset[pp] = 1'b0;
        last = pp;
      end
      exp_last = last;

      first = 1'b1;
      while (exp_port_q.size() > 0) begin
        pp = exp_port_q.pop_front();
        v  = exp_val_q.pop_front();
        recv_frame(pp, v, !first, $sformatf("rand%0d", it));
        first = 1'b0;
      end
      chk($sformatf("rand%0d_ovf", it), 32'(overflow), 32'(exp_ovf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_serializer.md
OUT_SERIALIZER -- requirements
Module: out_serializer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, flops in the ack synchronizer (legal range 2..3).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports p0, p1, p2, p3  input  16 each  processor output ports, synchronous to clk.
REQ-005 SHALL have port ack  input  1  external receiver acknowledge, asynchronous to clk.
REQ-006 SHALL have port data_out  output  8  byte being offered.
REQ-007 SHALL have port valid  output  1  data_out/port_id/hi are stable and offered.
REQ-008 SHALL have port port_id  output  2  source port of the current frame.
REQ-009 SHALL have port hi  output  1  0 = low byte, 1 = high byte of the frame.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port overflow  output  4  sticky per-port lost-update flags.

Function
REQ-012 SHALL keep a 16-bit shadow per port, loaded with pN every cycle; change_N = (pN != shadow_N).
REQ-013 On change_N, SHALL load snap_N <= pN and set pend_N the same edge.
REQ-014 If change_N occurs while pend_N is already 1 and port N is not being granted that cycle, SHALL overwrite snap_N and set overflow[N]; overflow bits clear only on reset.
REQ-015 SHALL run FSM states IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT.
REQ-016 IDLE: if any pend bit set, SHALL grant one port round-robin (search starts at last_grant+1 mod 4), load tx <= snap_g, port_id <= g, clear pend_g, go to LO_REQ.
REQ-017 If change_g coincides with the grant edge, SHALL send the old snap_g, load the new value into snap_g, keep pend_g = 1, and leave overflow[g] unchanged.
REQ-018 LO_REQ: valid=1, hi=0, data_out=tx[7:0]; on ack_s=1 SHALL go to LO_WAIT.
REQ-019 LO_WAIT: valid=0; on ack_s=0 SHALL go to HI_REQ.
REQ-020 HI_REQ: valid=1, hi=1, data_out=tx[15:8]; on ack_s=1 SHALL go to HI_WAIT.
REQ-021 HI_WAIT: valid=0; on ack_s=0 SHALL go to IDLE and update last_grant <= port_id.
REQ-022 ack_s SHALL be ack through SYNC_STAGES flops; valid SHALL fall at the first edge after ack_s reads 1, i.e. SYNC_STAGES+1 edges after ack rises.
REQ-023 data_out, port_id, hi SHALL be registered and SHALL NOT change while valid=1.
REQ-024 Changes on ports other than the one in flight SHALL only update snap/pend; tx SHALL be frozen for the whole frame.
REQ-025 Minimum frame length, with ack returned immediately, SHALL be 1 grant edge + 2*(2*(SYNC_STAGES+1)) edges; no frame-to-frame bubble beyond the IDLE grant cycle.
REQ-026 ack held high in IDLE SHALL be ignored; a new frame's LO_REQ waits until after LO_REQ entry to sample ack_s=1, which can advance it at once (receiver must follow four-phase protocol).

Reset
REQ-027 rst_n low SHALL asynchronously force: state=IDLE, valid=0, busy=0, data_out=0, port_id=0, hi=0, overflow=0, pend=0, shadows=0, snaps=0, sync flops=0, last_grant=3 (port 0 served first).
REQ-028 Reset mid-frame SHALL abort the frame with no further bytes; ports at 0 after release SHALL generate no frame; non-zero ports generate a frame one cycle after release.

Verification
REQ-029 p1 0x0000->0xBEEF, ack handshaken each byte -> bytes 0xEF (port_id=1, hi=0) then 0xBE (hi=1), busy falls after HI_WAIT, overflow=0.
REQ-030 p0=0x1111, p2=0x2222, p3=0x3333 changed same cycle -> frames in order port0, port2, port3.
REQ-031 p2 changes 0x0001, 0x0002, 0x0003 on consecutive cycles while port 0 in flight -> a single port2 frame 0x0003, overflow=4'b0100.
REQ-032 p1 changes 0x00AA then 0x00BB on the grant edge -> frame 0x00AA sent, then frame 0x00BB, overflow=0.
REQ-033 ack held low in LO_REQ for 100 cycles -> valid, data_out stay constant; ack rise -> valid falls exactly SYNC_STAGES+1 edges later.
REQ-034 rst_n pulsed low during HI_REQ -> valid=0, busy=0, overflow=0 immediately; no HI byte delivered after release.
